// File: rtl/wm8731_i2s_txrx.sv
// Purpose: I2S serializer that generates BCLK/LRC from clk, plus an oversampling I2S deserializer.
// Latency: tx data appears one BCLK after the slot start; rx word is ready ~3 clk after the last bit's BCLK rise.
// Backpressure: none; tx fetches a sample on every ren strobe, and rx words are strobed once with no hold.
module send_data_to_wm8731 #(
    parameter int SDSIZE    = 24,
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SDSIZE-1:0] tx_data,
    output logic              bclk,
    output logic              read_sync,
    output logic              ren,
    output logic              daclrc,
    output logic              dacdat,
    output logic              tx_data_valid
);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int KW = $clog2(SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(BCLK_DIV - 2);
    localparam logic [KW-1:0] K_LAST   = KW'(SLOT_BITS - 1);
    localparam logic [KW-1:0] K_DATA   = KW'(SDSIZE);

    logic [DW-1:0]     div;
    logic [KW-1:0]     k;
    logic [KW-1:0]     k_nxt;
    logic [SDSIZE-1:0] shreg;
    logic              div_wrap;
    logic              fall;
    logic              k_last;
    logic              pre_slot;

    assign div_wrap = (div == DIV_LAST);
    assign fall     = div_wrap & bclk;
    assign k_last   = (k == K_LAST);
    assign k_nxt    = k_last ? '0 : k + KW'(1);
    // read_sync must fire on the clk just before the slot-start fall
    assign pre_slot = (BCLK_DIV == 1) ? (~bclk & k_last)
                                      : ((div == DIV_PRE) & bclk & k_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div           <= '0;
            // k starts at its last value so the very first fall opens a left slot
            k             <= K_LAST;
            shreg         <= '0;
            bclk          <= 1'b0;
            daclrc        <= 1'b1;
            dacdat        <= 1'b0;
            ren           <= 1'b0;
            read_sync     <= 1'b0;
            tx_data_valid <= 1'b0;
        end else begin
            read_sync <= pre_slot;
            ren       <= 1'b0;
            if (div_wrap) begin
                div  <= '0;
                bclk <= ~bclk;
            end else begin
                div <= div + DW'(1);
            end
            if (fall) begin
                k <= k_nxt;
                if (k_last) begin
                    daclrc        <= ~daclrc;
                    shreg         <= tx_data;
                    dacdat        <= 1'b0;
                    tx_data_valid <= 1'b0;
                    ren           <= 1'b1;
                end else if (k_nxt <= K_DATA) begin
                    dacdat        <= shreg[SDSIZE-1];
                    shreg         <= {shreg[SDSIZE-2:0], 1'b0};
                    tx_data_valid <= 1'b1;
                end else begin
                    dacdat        <= 1'b0;
                    tx_data_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// Purpose: deserializes an I2S stream (oversampled BCLK) into {channel, sample} words.
// Latency: 2 sync flops + edge detect, so the word lands ~3 clk after the final BCLK rise.
// Backpressure: none; rx_data_valid is a single-clk strobe and the word holds until the next one.
module receive_data_from_i2s #(
    parameter int SDSIZE = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_bclk,
    input  logic              rx_lrc,
    input  logic              rx_dat,
    output logic [SDSIZE:0]   rx_data,
    output logic              rx_data_valid
);
    localparam int CW = $clog2(SDSIZE + 2);
    localparam logic [CW-1:0] C_LAST = CW'(SDSIZE - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(SDSIZE);

    logic [2:0]        bclk_sy;
    logic [1:0]        lrc_sy;
    logic [1:0]        dat_sy;
    logic              rise;
    logic              lrc_s;
    logic              dat_s;
    logic              prev_lrc;
    logic              armed;
    logic [CW-1:0]     cnt;
    logic [SDSIZE-2:0] shreg;

    // bclk gets a third stage for edge detection; lrc/dat taps stay aligned with bclk_sy[1]
    assign rise  = bclk_sy[1] & ~bclk_sy[2];
    assign lrc_s = lrc_sy[1];
    assign dat_s = dat_sy[1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            bclk_sy       <= '0;
            lrc_sy        <= '0;
            dat_sy        <= '0;
            prev_lrc      <= 1'b1;
            armed         <= 1'b0;
            cnt           <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
        end else begin
            bclk_sy       <= {bclk_sy[1:0], rx_bclk};
            lrc_sy        <= {lrc_sy[0], rx_lrc};
            dat_sy        <= {dat_sy[0], rx_dat};
            rx_data_valid <= 1'b0;
            if (rise) begin
                if (lrc_s != prev_lrc) begin
                    // LRC change wins over any in-flight bit, including the last one
                    prev_lrc <= lrc_s;
                    armed    <= 1'b1;
                    cnt      <= '0;
                    shreg    <= '0;
                end else if (armed && (cnt <= C_MAX)) begin
                    cnt <= cnt + CW'(1);
                    if (cnt < C_MAX) begin
                        shreg <= {shreg[SDSIZE-3:0], dat_s};
                    end
                    if (cnt == C_LAST) begin
                        rx_data       <= {prev_lrc, shreg, dat_s};
                        rx_data_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// Purpose: WM8731 I2S link top; transmitter and receiver share clk, loopback is wired outside.
// Latency: see submodules; no extra pipeline stages at this level.
// Backpressure: none; the sample source must present tx_data before each ren.
module wm8731_i2s_txrx #(
    parameter int SDSIZE    = 24,
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SDSIZE-1:0] tx_data,
    output logic              bclk,
    output logic              read_sync,
    output logic              ren,
    output logic              daclrc,
    output logic              dacdat,
    output logic              tx_data_valid,
    input  logic              rx_bclk,
    input  logic              rx_lrc,
    input  logic              rx_dat,
    output logic [SDSIZE:0]   rx_data,
    output logic              rx_data_valid
);
    send_data_to_wm8731 #(
        .SDSIZE   (SDSIZE),
        .BCLK_DIV (BCLK_DIV),
        .SLOT_BITS(SLOT_BITS)
    ) u_tx (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .bclk         (bclk),
        .read_sync    (read_sync),
        .ren          (ren),
        .daclrc       (daclrc),
        .dacdat       (dacdat),
        .tx_data_valid(tx_data_valid)
    );

    receive_data_from_i2s #(
        .SDSIZE(SDSIZE)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_bclk      (rx_bclk),
        .rx_lrc       (rx_lrc),
        .rx_dat       (rx_dat),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid)
    );
endmodule

// File: tb/tb_wm8731_i2s_txrx.sv
// Directed bench for wm8731_i2s_txrx: reset, clocking, loopback, serial format, mid-frame reset, short slots.
module tb_wm8731_i2s_txrx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] tx_data = 24'h123456;
    logic        bclk, read_sync, ren, daclrc, dacdat, tx_data_valid;
    logic        rx_bclk, rx_lrc, rx_dat;
    logic [24:0] rx_data;
    logic        rx_data_valid;

    logic        lb = 1'b1;
    logic        m_bclk = 1'b0;
    logic        m_lrc = 1'b1;
    logic        m_dat = 1'b0;
    logic        fixed_mode = 1'b0;

    int          n_tests = 0;
    int          n_fail = 0;
    int          vcnt = 0;
    int          pidx = 0;
    logic [24:0] rxq[$];
    logic [23:0] pat[4] = '{24'h123456, 24'h345678, 24'h567890, 24'h901234};

    assign rx_bclk = lb ? bclk   : m_bclk;
    assign rx_lrc  = lb ? daclrc : m_lrc;
    assign rx_dat  = lb ? dacdat : m_dat;

    wm8731_i2s_txrx dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data      (tx_data),
        .bclk         (bclk),
        .read_sync    (read_sync),
        .ren          (ren),
        .daclrc       (daclrc),
        .dacdat       (dacdat),
        .tx_data_valid(tx_data_valid),
        .rx_bclk      (rx_bclk),
        .rx_lrc       (rx_lrc),
        .rx_dat       (rx_dat),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid)
    );

    always #5 clk = ~clk;

    // Collect received words and advance the sample source on each ren
    always @(negedge clk) begin
        if (rx_data_valid) begin
            rxq.push_back(rx_data);
            vcnt = vcnt + 1;
        end
        if (ren) begin
            pidx = (pidx + 1) % 4;
            tx_data = fixed_mode ? 24'h800001 : pat[pidx];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ren(input string tag);
        int c = 0;
        do begin
            tick(1);
            c++;
        end while (!ren && c < 400);
        check(tag, {31'b0, ren}, 32'h1);
    endtask

    task automatic send_bit(input logic l, input logic d);
        m_lrc  = l;
        m_dat  = d;
        m_bclk = 1'b0;
        tick(4);
        m_bclk = 1'b1;
        tick(4);
    endtask

    task automatic send_slot(input logic l, input logic [23:0] data, input int nbits);
        send_bit(l, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(l, data[23-i]);
    endtask

    function automatic logic [31:0] qget(input int idx);
        if (idx < rxq.size()) return {7'b0, rxq[idx]};
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        int          first_rise, second_rise, first_fall;
        int          ren_t[$];
        int          rs_t[$];
        logic        lrc_at_ren[$];
        logic        prev_bclk;
        logic [31:0] obs;
        int          vc, v0, c;

        // Reset
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_bclk", {31'b0, bclk}, 32'h0);
        end
        check("rst_daclrc", {31'b0, daclrc}, 32'h1);
        check("rst_dacdat", {31'b0, dacdat}, 32'h0);
        check("rst_ren", {31'b0, ren}, 32'h0);
        check("rst_read_sync", {31'b0, read_sync}, 32'h0);
        check("rst_txvalid", {31'b0, tx_data_valid}, 32'h0);
        check("rst_rx_data", {7'b0, rx_data}, 32'h0);
        check("rst_rxvalid", {31'b0, rx_data_valid}, 32'h0);

        // Clocking + loopback
        rst = 1'b1;
        first_rise = -1; second_rise = -1; first_fall = -1; prev_bclk = 1'b0;
        for (int cy = 1; cy <= 1600; cy++) begin
            tick(1);
            if (bclk && !prev_bclk) begin
                if (first_rise < 0) first_rise = cy;
                else if (second_rise < 0) second_rise = cy;
            end
            if (!bclk && prev_bclk && first_fall < 0) first_fall = cy;
            prev_bclk = bclk;
            if (ren) begin
                ren_t.push_back(cy);
                lrc_at_ren.push_back(daclrc);
            end
            if (read_sync) rs_t.push_back(cy);
        end
        check("bclk_first_rise", first_rise, 4);
        check("bclk_second_rise", second_rise, 12);
        check("bclk_first_fall", first_fall, 8);
        check("ren_count", ren_t.size(), 7);
        check("read_sync_count", rs_t.size(), 7);
        check("ren_first", (ren_t.size() > 0) ? ren_t[0] : -1, 8);
        check("ren_period", (ren_t.size() > 1) ? ren_t[1] - ren_t[0] : -1, 256);
        check("read_sync_first", (rs_t.size() > 0) ? rs_t[0] : -1, 7);
        check("read_sync_second", (rs_t.size() > 1) ? rs_t[1] : -1, 263);
        check("lrc_at_ren0", (lrc_at_ren.size() > 0) ? {31'b0, lrc_at_ren[0]} : 32'hF, 32'h0);
        check("lrc_at_ren1", (lrc_at_ren.size() > 1) ? {31'b0, lrc_at_ren[1]} : 32'hF, 32'h1);
        check("lb_word_count", vcnt, 6);
        check("lb_word0", qget(0), 32'h0123456);
        check("lb_word1", qget(1), 32'h1345678);
        check("lb_word2", qget(2), 32'h0567890);
        check("lb_word3", qget(3), 32'h1901234);
        check("lb_word4", qget(4), 32'h0123456);
        check("lb_word5", qget(5), 32'h1345678);

        // Serial format with 24'h800001
        fixed_mode = 1'b1;
        wait_ren("ser_ren_a");
        wait_ren("ser_ren_b");
        obs = '0;
        vc = 0;
        for (int i = 1; i < 256; i++) begin
            tick(1);
            if (i % 8 == 4) obs[i/8] = dacdat;
            if (tx_data_valid) vc++;
        end
        check("ser_dacdat_bits", obs, 32'h0100_0002);
        check("ser_txvalid_clks", vc, 192);

        // Reset at k=10 of a slot
        wait_ren("mid_ren");
        tick(84);
        v0 = vcnt;
        rst = 1'b0;
        tick(3);
        check("mid_rst_rx_data", {7'b0, rx_data}, 32'h0);
        check("mid_rst_daclrc", {31'b0, daclrc}, 32'h1);
        rst = 1'b1;
        c = 0;
        while (vcnt == v0 && c < 600) begin
            tick(1);
            c++;
        end
        check("mid_first_word_time", {31'b0, (c >= 205 && c <= 213)}, 32'h1);
        check("mid_first_word", qget(v0), 32'h0800001);

        // Short slot and LRC-on-last-bit aborts, driven directly
        lb = 1'b0;
        m_bclk = 1'b0;
        m_lrc = 1'b1;
        m_dat = 1'b0;
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
        v0 = vcnt;
        send_slot(1'b0, 24'hABCDEF, 12);
        tick(8);
        check("short_no_valid", vcnt - v0, 0);
        send_slot(1'b1, 24'h13579B, 24);
        send_slot(1'b0, 24'h2468AC, 23);
        send_slot(1'b1, 24'hFEDCBA, 24);
        send_slot(1'b0, 24'h654321, 24);
        tick(8);
        check("man_word_count", vcnt - v0, 3);
        check("man_word0", qget(v0), 32'h113579B);
        check("man_word1", qget(v0 + 1), 32'h1FEDCBA);
        check("man_word2", qget(v0 + 2), 32'h0654321);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
